// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared widths and FSM state type for the memory port arbiter.
package mem_arb_pkg;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    typedef enum logic {ARB, LOCKED} arb_state_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side bundle of the shared BRAM port.
interface mem_port_arbiter_if #(parameter int NUM_REQ = 2, parameter int ADDR_W = 13);
    import mem_arb_pkg::*;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*BE_W-1:0]   req_be;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [BE_W-1:0]           mem_be;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_rdata;
    modport master (
        output req_valid, req_addr, req_wdata, req_be, req_we, req_lock, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_be, mem_we
    );
    modport slave (
        input  req_valid, req_addr, req_wdata, req_be, req_we, req_lock, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_be, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter_picker.sv
// rr_priority_picker: picks the first valid requester at or after ptr+1 (mod NUM_REQ).
module rr_priority_picker #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);
    // Scan from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (valid_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                idx_o = IW'((int'(ptr_i) + k) % NUM_REQ);
                any_o = 1'b1;
            end
    end
    assign grant_o = any_o ? NUM_REQ'(1) << idx_o : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one BRAM port with 1-cycle response routing.
// Optional grant locking for atomic sequences is enabled by defining MEM_ARB_LOCK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 13
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              we;
    } mem_req_t;
    mem_req_t           req [NUM_REQ];
    mem_req_t           sel;
    arb_state_e         state_q;
    logic [IW-1:0]      ptr_q, rsp_id_q, win;
    logic               rsp_pend_q, any;
    logic [NUM_REQ-1:0] elig, grant;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign req[g] = '{addr:  bus.req_addr[g*ADDR_W +: ADDR_W],
                          wdata: bus.req_wdata[g*DATA_W +: DATA_W],
                          be:    bus.req_be[g*BE_W +: BE_W],
                          we:    bus.req_we[g]};
    end
`ifdef MEM_ARB_LOCK_EN
    logic [IW-1:0] owner_q;
    assign elig = state_q == LOCKED ? bus.req_valid & (NUM_REQ'(1) << owner_q) : bus.req_valid;
`else
    assign elig = state_q == ARB ? bus.req_valid : '0;
`endif
    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid_i(elig),
        .ptr_i  (ptr_q),
        .grant_o(grant),
        .idx_o  (win),
        .any_o  (any)
    );
    assign sel           = req[win];
    assign bus.req_ready = grant;
    assign bus.mem_addr  = any ? sel.addr : '0;
    assign bus.mem_wdata = any ? sel.wdata : '0;
    assign bus.mem_be    = any ? sel.be : '0;
    assign bus.mem_we    = any & sel.we;
    assign bus.rsp_valid = rsp_pend_q ? NUM_REQ'(1) << rsp_id_q : '0;
    assign bus.rsp_rdata = bus.mem_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= IW'(NUM_REQ - 1);
            rsp_id_q   <= '0;
            rsp_pend_q <= 1'b0;
            state_q    <= ARB;
`ifdef MEM_ARB_LOCK_EN
            owner_q    <= '0;
`endif
        end else begin
            rsp_pend_q <= any;
            if (any) begin
                rsp_id_q <= win;
                ptr_q    <= win;
            end
`ifdef MEM_ARB_LOCK_EN
            if (state_q == ARB && any && bus.req_lock[win]) begin
                state_q <= LOCKED;
                owner_q <= win;
            end else if (state_q == LOCKED && !bus.req_lock[owner_q])
                state_q <= ARB;
`endif
        end
    end
endmodule
